// File: rtl/lower_mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lower_mem_pkg: shared types and helpers for lower_mem_responder     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package lower_mem_pkg;

  localparam int COUNT_W = 16;
  localparam int LAT_W   = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_REQ   = 3'd2,
    RD_DRIVE = 3'd3,
    WR_WAIT  = 3'd4,
    WR_DONE  = 3'd5,
    ABORT    = 3'd6
  } mem_state_t;

  // Unwritten words read back as their own address.
  function automatic logic [63:0] default_data(input logic [63:0] addr);
    return addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lower_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lower_mem_responder_if: shared-bus signals seen by the memory       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface lower_mem_responder_if #(
  parameter int ADDRESSSIZE = 32
);

  logic                              BusRd;
  logic                              BusRdX;
  logic                              Mem_wr;
  logic                              Mem_oprn_abort;
  logic [ADDRESSSIZE-1:0]            Address_Com;
  logic [ADDRESSSIZE-1:0]            Data_Bus_Com_in;
  logic [ADDRESSSIZE-1:0]            Data_Bus_Com_out;
  logic                              Data_Bus_Com_oe;
  logic                              Data_in_Bus;
  logic                              Mem_snoop_req;
  logic                              Mem_snoop_gnt;
  logic                              Mem_write_done;
  logic [lower_mem_pkg::COUNT_W-1:0] rd_count;
  logic [lower_mem_pkg::COUNT_W-1:0] wr_count;

  modport master (
    output BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Address_Com,
           Data_Bus_Com_in, Mem_snoop_gnt,
    input  Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_snoop_req,
           Mem_write_done, rd_count, wr_count
  );

  modport slave (
    input  BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Address_Com,
           Data_Bus_Com_in, Mem_snoop_gnt,
    output Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_snoop_req,
           Mem_write_done, rd_count, wr_count
  );

endinterface
`default_nettype wire

// File: rtl/lower_mem_responder_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_backing_store: word array with per-word valid bits              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_backing_store
  import lower_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  we,
  input  wire logic [DEPTH_LOG2-1:0] waddr,
  input  wire logic [DATA_W-1:0]     wdata,
  input  wire logic [DATA_W-1:0]     raddr,
  output logic      [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH_LOG2-1:0] w_ridx;

  assign w_ridx = raddr[DEPTH_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[waddr] <= 1'b1;
    end
  end

  // Data array has no reset; a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = DATA_W'(default_data(64'(raddr)));
    if (r_valid[w_ridx]) begin
      rdata = mem[w_ridx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/lower_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lower_mem_responder: shared-bus memory servicing fills/write-backs  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module lower_mem_responder
  import lower_mem_pkg::*;
#(
  parameter int ADDRESSSIZE    = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 4,
  parameter int WR_LATENCY     = 2
) (
  input wire logic             clk,
  input wire logic             rst,
  lower_mem_responder_if.slave bus
);

  mem_state_t             r_state;
  logic [LAT_W-1:0]       r_cnt;
  logic [ADDRESSSIZE-1:0] r_addr;
  logic [ADDRESSSIZE-1:0] r_wdata;
  logic [ADDRESSSIZE-1:0] r_dout;
  logic                   r_oe;
  logic                   r_dib;
  logic                   r_req;
  logic                   r_done;
  logic [COUNT_W-1:0]     r_rd_count;
  logic [COUNT_W-1:0]     r_wr_count;

  logic                   w_rd_any;
  logic                   w_we;
  logic [ADDRESSSIZE-1:0] w_rdata;

  assign w_rd_any = bus.BusRd | bus.BusRdX;
  assign w_we     = (r_state == WR_WAIT) && (r_cnt == LAT_W'(1));

  mem_backing_store #(
    .DATA_W     (ADDRESSSIZE),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (r_addr[MEM_DEPTH_LOG2-1:0]),
    .wdata (r_wdata),
    .raddr (r_addr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dout     <= '0;
      r_oe       <= 1'b0;
      r_dib      <= 1'b0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Mem_wr) begin
            r_addr  <= bus.Address_Com;
            r_wdata <= bus.Data_Bus_Com_in;
            r_cnt   <= LAT_W'(WR_LATENCY);
            r_state <= WR_WAIT;
          end else if (w_rd_any) begin
            r_addr  <= bus.Address_Com;
            r_cnt   <= LAT_W'(RD_LATENCY);
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // An abort landing on the final count still suppresses the request.
          if (bus.Mem_oprn_abort) begin
            r_state <= ABORT;
          end else if (!w_rd_any) begin
            r_state <= IDLE;
          end else if (r_cnt == LAT_W'(1)) begin
            r_req   <= 1'b1;
            r_state <= RD_REQ;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        RD_REQ: begin
          if (bus.Mem_oprn_abort) begin
            r_req   <= 1'b0;
            r_state <= ABORT;
          end else if (!w_rd_any) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else if (bus.Mem_snoop_gnt) begin
            r_dout  <= w_rdata;
            r_oe    <= 1'b1;
            r_dib   <= 1'b1;
            r_state <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (!w_rd_any) begin
            r_dout  <= '0;
            r_oe    <= 1'b0;
            r_dib   <= 1'b0;
            r_req   <= 1'b0;
            r_state <= IDLE;
            if (r_rd_count != '1) begin
              r_rd_count <= r_rd_count + COUNT_W'(1);
            end
          end
        end
        WR_WAIT: begin
          if (r_cnt == LAT_W'(1)) begin
            r_done  <= 1'b1;
            r_state <= WR_DONE;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        WR_DONE: begin
          if (!bus.Mem_wr) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
            if (r_wr_count != '1) begin
              r_wr_count <= r_wr_count + COUNT_W'(1);
            end
          end
        end
        ABORT: begin
          if (!w_rd_any) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Data_Bus_Com_out = r_dout;
  assign bus.Data_Bus_Com_oe  = r_oe;
  assign bus.Data_in_Bus      = r_dib;
  assign bus.Mem_snoop_req    = r_req;
  assign bus.Mem_write_done   = r_done;
  assign bus.rd_count         = r_rd_count;
  assign bus.wr_count         = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_lower_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lower_mem_responder: directed vector bench for the memory        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_lower_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lower_mem_responder_if #(.ADDRESSSIZE(32)) bus ();

  lower_mem_responder #(
    .ADDRESSSIZE    (32),
    .MEM_DEPTH_LOG2 (10),
    .RD_LATENCY     (4),
    .WR_LATENCY     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // in  = {BusRd, BusRdX, Mem_wr, Mem_oprn_abort, Mem_snoop_gnt}
  // out = {Mem_snoop_req, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done}
  typedef struct {
    logic [4:0]  in;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  out;
    logic [31:0] dout;
    logic [15:0] rdc;
    logic [15:0] wrc;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input logic [4:0] in, input logic [31:0] addr, input logic [31:0] din,
                              input logic [3:0] out, input logic [31:0] dout,
                              input logic [15:0] rdc, input logic [15:0] wrc);
    vec_t v;
    v.in = in; v.addr = addr; v.din = din; v.out = out; v.dout = dout; v.rdc = rdc; v.wrc = wrc;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic [4:0] in, input logic [31:0] addr, input logic [31:0] din);
    bus.BusRd           = in[4];
    bus.BusRdX          = in[3];
    bus.Mem_wr          = in[2];
    bus.Mem_oprn_abort  = in[1];
    bus.Mem_snoop_gnt   = in[0];
    bus.Address_Com     = addr;
    bus.Data_Bus_Com_in = din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] out, input logic [31:0] dout,
                       input logic [15:0] rdc, input logic [15:0] wrc);
    logic [3:0] got;
    got = {bus.Mem_snoop_req, bus.Data_Bus_Com_oe, bus.Data_in_Bus, bus.Mem_write_done};
    n_tests++;
    if (got !== out || bus.Data_Bus_Com_out !== dout || bus.rd_count !== rdc || bus.wr_count !== wrc) begin
      n_fail++;
      $display("FAIL %s: got req/oe/dib/done=%b dout=%h rd_count=%0d wr_count=%0d, expected %b dout=%h rd_count=%0d wr_count=%0d",
               name, got, bus.Data_Bus_Com_out, bus.rd_count, bus.wr_count, out, dout, rdc, wrc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // sel 0 waits for Mem_snoop_req, sel 1 for Mem_write_done; returns cycles taken.
  task automatic wait_for(input string name, input int sel, output int n);
    n = 0;
    while (((sel == 0) ? bus.Mem_snoop_req : bus.Mem_write_done) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (((sel == 0) ? bus.Mem_snoop_req : bus.Mem_write_done) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, expected signal high", name, n);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [15:0] rdc,
                          input logic [15:0] wrc);
    int n;
    drive(5'b00100, addr, data);
    wait_for("sat_write_done", 1, n);
    drive(5'b00000, addr, 32'h0);
    tick();
    check("sat_write_count", 4'b0000, 32'h0, rdc, wrc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // cold read of 0x40, grant two cycles after the request
    repeat (4) add(5'b10000, 32'h40, 32'h0, 4'b0000, 32'h0, 0, 0);
    add(5'b10000, 32'h40, 32'h0, 4'b1000, 32'h0, 0, 0);
    add(5'b10000, 32'h40, 32'h0, 4'b1000, 32'h0, 0, 0);
    add(5'b10001, 32'h40, 32'h0, 4'b1110, 32'h40, 0, 0);
    add(5'b10000, 32'h40, 32'h0, 4'b1110, 32'h40, 0, 0);
    add(5'b00000, 32'h40, 32'h0, 4'b0000, 32'h0, 1, 0);
    // write-back 0x10 then BusRdX of the same word
    repeat (2) add(5'b00100, 32'h10, 32'hDEADBEEF, 4'b0000, 32'h0, 1, 0);
    repeat (2) add(5'b00100, 32'h10, 32'hDEADBEEF, 4'b0001, 32'h0, 1, 0);
    add(5'b00000, 32'h10, 32'h0, 4'b0000, 32'h0, 1, 1);
    repeat (4) add(5'b01000, 32'h10, 32'h0, 4'b0000, 32'h0, 1, 1);
    add(5'b01000, 32'h10, 32'h0, 4'b1000, 32'h0, 1, 1);
    add(5'b01001, 32'h10, 32'h0, 4'b1110, 32'hDEADBEEF, 1, 1);
    add(5'b00000, 32'h10, 32'h0, 4'b0000, 32'h0, 2, 1);
    // aliased address 0x410 maps onto word 0x10
    repeat (4) add(5'b10000, 32'h410, 32'h0, 4'b0000, 32'h0, 2, 1);
    add(5'b10000, 32'h410, 32'h0, 4'b1000, 32'h0, 2, 1);
    add(5'b10001, 32'h410, 32'h0, 4'b1110, 32'hDEADBEEF, 2, 1);
    add(5'b00000, 32'h410, 32'h0, 4'b0000, 32'h0, 3, 1);
    // abort two cycles after detection: request never rises
    repeat (2) add(5'b10000, 32'h20, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b10010, 32'h20, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b10001, 32'h20, 32'h0, 4'b0000, 32'h0, 3, 1);
    repeat (2) add(5'b10000, 32'h20, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b00000, 32'h20, 32'h0, 4'b0000, 32'h0, 3, 1);
    // requester withdraws while waiting, then invalidate-only traffic
    repeat (2) add(5'b10000, 32'h50, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b00001, 32'h50, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b00000, 32'h50, 32'h0, 4'b0000, 32'h0, 3, 1);
    // abort while requesting drops the request
    repeat (4) add(5'b10000, 32'h60, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b10000, 32'h60, 32'h0, 4'b1000, 32'h0, 3, 1);
    add(5'b10010, 32'h60, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b00000, 32'h60, 32'h0, 4'b0000, 32'h0, 3, 1);
    // abort ignored while driving
    repeat (4) add(5'b10000, 32'h60, 32'h0, 4'b0000, 32'h0, 3, 1);
    add(5'b10000, 32'h60, 32'h0, 4'b1000, 32'h0, 3, 1);
    add(5'b10001, 32'h60, 32'h0, 4'b1110, 32'h60, 3, 1);
    add(5'b10010, 32'h60, 32'h0, 4'b1110, 32'h60, 3, 1);
    add(5'b00000, 32'h60, 32'h0, 4'b0000, 32'h0, 4, 1);
    // abort ignored during a write, then read the written word
    repeat (2) add(5'b00110, 32'h70, 32'hCAFEF00D, 4'b0000, 32'h0, 4, 1);
    add(5'b00110, 32'h70, 32'hCAFEF00D, 4'b0001, 32'h0, 4, 1);
    add(5'b00000, 32'h70, 32'h0, 4'b0000, 32'h0, 4, 2);
    repeat (4) add(5'b01000, 32'h70, 32'h0, 4'b0000, 32'h0, 4, 2);
    add(5'b01000, 32'h70, 32'h0, 4'b1000, 32'h0, 4, 2);
    add(5'b01001, 32'h70, 32'h0, 4'b1110, 32'hCAFEF00D, 4, 2);
    add(5'b00000, 32'h70, 32'h0, 4'b0000, 32'h0, 5, 2);

    rst = 1'b1;
    drive(5'b00000, 32'h0, 32'h0);
    tick();
    tick();
    check("reset", 4'b0000, 32'h0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in, tbl[i].addr, tbl[i].din);
      tick();
      check($sformatf("vec%0d", i), tbl[i].out, tbl[i].dout, tbl[i].rdc, tbl[i].wrc);
    end

    // simultaneous write and read: write completes first
    drive(5'b10100, 32'h30, 32'h12345678);
    wait_for("simul_write_done", 1, n);
    check_int("simul_write_latency", n, 3);
    check("simul_no_req_during_write", 4'b0001, 32'h0, 5, 2);
    drive(5'b10000, 32'h30, 32'h0);
    tick();
    check("simul_write_commit", 4'b0000, 32'h0, 5, 3);
    wait_for("simul_read_req", 0, n);
    check_int("simul_read_latency", n, 5);
    drive(5'b10001, 32'h30, 32'h0);
    tick();
    check("simul_read_data", 4'b1110, 32'h12345678, 5, 3);
    drive(5'b00000, 32'h30, 32'h0);
    tick();
    check("simul_read_done", 4'b0000, 32'h0, 6, 3);

    // reset while driving a fill of a written word
    drive(5'b10000, 32'h10, 32'h0);
    wait_for("rstfill_req", 0, n);
    drive(5'b10001, 32'h10, 32'h0);
    tick();
    check("rstfill_drive", 4'b1110, 32'hDEADBEEF, 6, 3);
    rst = 1'b1;
    drive(5'b10000, 32'h10, 32'h0);
    tick();
    check("rstfill_reset", 4'b0000, 32'h0, 0, 0);
    rst = 1'b0;
    drive(5'b00000, 32'h10, 32'h0);
    tick();
    drive(5'b10000, 32'h10, 32'h0);
    wait_for("rstfill_reread_req", 0, n);
    drive(5'b10001, 32'h10, 32'h0);
    tick();
    check("rstfill_invalidated", 4'b1110, 32'h10, 0, 0);
    drive(5'b00000, 32'h10, 32'h0);
    tick();
    check("rstfill_reread_done", 4'b0000, 32'h0, 1, 0);

    // saturation: preload the write counter near its ceiling
    force dut.r_wr_count = 16'hFFFE;
    tick();
    release dut.r_wr_count;
    do_write(32'h80, 32'h1, 1, 16'hFFFF);
    do_write(32'h84, 32'h2, 1, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lower_mem_responder.md
Name: lower_mem_responder

Overview:
Synthesizable lower-level memory that sits on the shared bus below the 4-core MESI L1 caches. It responds to BusRd/BusRdX fills and Mem_wr write-backs. It requests the bus from the arbiter before driving fill data. It cancels a fill when a snooping cache supplies the data instead, signalled by Mem_oprn_abort.

Parameters:
ADDRESSSIZE, 32, address and data word width
MEM_DEPTH_LOG2, 10, backing store holds 2**MEM_DEPTH_LOG2 words, indexed by Address_Com[MEM_DEPTH_LOG2-1:0]
RD_LATENCY, 4, cycles from read detection to Mem_snoop_req assertion; must be >= 1
WR_LATENCY, 2, cycles from write detection to Mem_write_done assertion; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
BusRd  in  1  bus read request from a cache
BusRdX  in  1  bus read-for-ownership request
Mem_wr  in  1  write-back request; data is valid on Data_Bus_Com_in
Mem_oprn_abort  in  1  a snooping cache supplies data, so abort the pending fill
Address_Com  in  ADDRESSSIZE  shared bus address
Data_Bus_Com_in  in  ADDRESSSIZE  shared data bus, sampled during a write
Data_Bus_Com_out  out  ADDRESSSIZE  fill data
Data_Bus_Com_oe  out  1  drive enable for Data_Bus_Com_out (the top-level tristate)
Data_in_Bus  out  1  fill data valid
Mem_snoop_req  out  1  memory bus request to the arbiter
Mem_snoop_gnt  in  1  arbiter grant to memory
Mem_write_done  out  1  write-back committed
rd_count  out  16  completed fills, saturating
wr_count  out  16  committed writes, saturating

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE; all outputs 0; Data_Bus_Com_out=0; counters=0; all valid bits cleared. Reset mid-transaction abandons the transaction with no array update.
- Storage: word array plus one valid bit per word. Reading an invalid word returns the requested address value itself, giving a deterministic pattern.
- States: IDLE, RD_WAIT, RD_REQ, RD_DRIVE, WR_WAIT, WR_DONE, ABORT.
- IDLE:
  - Mem_wr=1: latch Address_Com and Data_Bus_Com_in, load the counter with WR_LATENCY, go to WR_WAIT.
  - Else BusRd|BusRdX=1: latch Address_Com, load the counter with RD_LATENCY, go to RD_WAIT.
  - Mem_wr has priority when asserted together with a read.
- RD_WAIT: decrement the counter; at 1, go to RD_REQ.
  - Mem_snoop_req rises exactly RD_LATENCY cycles after the detection edge.
- RD_REQ: hold Mem_snoop_req=1. When Mem_snoop_gnt is sampled 1, go to RD_DRIVE.
- RD_DRIVE (entered the cycle after the grant):
  - Drive Data_Bus_Com_out from the store, with Data_Bus_Com_oe=1, Data_in_Bus=1 and Mem_snoop_req=1.
  - Stay until BusRd=0 and BusRdX=0; then all outputs go low the next cycle, rd_count increments, state goes to IDLE.
- Abort:
  - Mem_oprn_abort=1 sampled in RD_WAIT or RD_REQ: go to ABORT. Mem_snoop_req drops next cycle and nothing is driven.
  - ABORT waits for BusRd=0 and BusRdX=0, then goes to IDLE.
  - Abort is ignored in RD_DRIVE, WR_WAIT and WR_DONE.
- Requester withdraws (BusRd=0 and BusRdX=0) in RD_WAIT or RD_REQ: go to IDLE, no drive, rd_count unchanged.
- WR_WAIT: decrement the counter. At 1, write the array, set the valid bit, go to WR_DONE.
- WR_DONE: Mem_write_done=1 until Mem_wr is sampled 0. Then clear it the next cycle, wr_count increments, go to IDLE.
- Read-after-write: a fill detected after WR_DONE returns the new data.
- Invalidate-only bus traffic (no BusRd/BusRdX/Mem_wr) is ignored.
- Address aliasing above MEM_DEPTH_LOG2 is permitted.
- Counters saturate at 16'hFFFF.
- Outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package lower_mem_pkg: state enum mem_state_t; default-data function (returns the address); counter width constant.
- Sub-module mem_backing_store: the array plus valid bits, one synchronous write port and one read port, with valid clear on rst.

Test Plan:
- Cold read: BusRd=1, Address_Com=32'h0000_0040, grant 2 cycles after the request -> Mem_snoop_req high at +4 cycles; Data_Bus_Com_out=32'h0000_0040 with oe=1 and Data_in_Bus=1 until BusRd drops; rd_count=1.
- Write then read: Mem_wr=1, addr 32'h10, data 32'hDEADBEEF -> Mem_write_done at +2 cycles, held until Mem_wr=0, wr_count=1; a following BusRdX to 32'h10 returns 32'hDEADBEEF.
- Abort: BusRd to 32'h20, Mem_oprn_abort=1 at +2 cycles -> Mem_snoop_req never asserts; oe stays 0; rd_count=0; IDLE after BusRd drops.
- Simultaneous: Mem_wr and BusRd both 1 in IDLE -> the write completes first; the read is then serviced once Mem_wr drops and BusRd remains high.
- Reset mid-fill: rst=1 in RD_DRIVE -> next cycle all outputs 0, state IDLE; a subsequent read of a previously written address returns the address pattern because valid bits are cleared.
- Saturation: force 65537 writes -> wr_count stays at 16'hFFFF.
